mult_rr_scheduler: RTL and testbench

Time-shares one combinational unsigned multiplier among NUM_REQ requesters using round-robin arbitration.
- Requesters present operands with a valid/ready handshake.
- The block drives the shared multiplier and registers the product.
- The product is returned on a single response channel, tagged with the requester index.
- It sits between the requesting datapath blocks and the 4x4 shift-add multiplier instance (operands WIDTH, product 2*WIDTH).

---
 rtl/mult_rr_scheduler_pkg.sv | 25 ++
 rtl/mult_rr_scheduler_rr_arbiter.sv | 64 ++++++
 rtl/mult_rr_scheduler.sv | 161 ++++++++++++++++
 tb/tb_mult_rr_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_rr_scheduler_pkg.sv
// Shared constants, FSM state encoding and response-tag width helper for the
// round-robin multiplier scheduler.
package mult_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_CALC = S_CALC,
        ST_RESP = S_RESP
    } sched_state_t;

    // A single requester still needs a one-bit tag.
    function automatic int calc_id_w(input int num_req);
        int w;
        w = (num_req > 1) ? $clog2(num_req) : 1;
        return w;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the slot after ptr
// and wraps modulo NUM_REQ.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx
);

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    int                 w_ofs;
    int                 w_idx;
    int                 w_pos;

    // Rotate the request vector so the slot after ptr lands on bit 0.
    always_comb begin
        w_rot = '0;
        w_pos = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(ptr) + 1 + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end else begin
                w_pos = w_pos;
            end
            w_rot[k] = req[ID_W'(w_pos)];
        end
    end

    // Lowest set bit of the rotated vector wins; map it back to an absolute index.
    always_comb begin
        w_found = 1'b0;
        w_ofs   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_ofs   = k;
            end else begin
                w_ofs   = w_ofs;
            end
        end
        w_idx = int'(ptr) + 1 + w_ofs;
        if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
        end else begin
            w_idx = w_idx;
        end
        grant_onehot = '0;
        grant_idx    = '0;
        if (w_found) begin
            grant_idx                   = ID_W'(w_idx);
            grant_onehot[ID_W'(w_idx)]  = 1'b1;
        end else begin
            grant_idx                   = '0;
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Time-shares one external combinational multiplier among NUM_REQ requesters.
// Optional macro MULT_SCHED_ZERO_SKIP_EN: a zero operand bypasses CALC.
module mult_rr_scheduler
    import mult_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product
);

    sched_state_t       r_state;
    sched_state_t       w_next_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_op_id;
    logic [ID_W-1:0]    r_rsp_id;
    logic [ID_W-1:0]    w_grant_idx;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [NUM_REQ-1:0] w_grant_onehot;
    logic [2*WIDTH-1:0] r_rsp_product;
    logic               r_rsp_valid;
    logic               w_accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req          (req_valid),
        .ptr          (r_ptr),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx)
    );

    assign w_sel_a  = req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_sel_b  = req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_accept = (r_state == ST_IDLE) && (|req_valid);

`ifdef MULT_SCHED_ZERO_SKIP_EN
    logic w_zero_op;
    assign w_zero_op = (w_sel_a == {WIDTH{1'b0}}) || (w_sel_b == {WIDTH{1'b0}});
`endif

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;

    // Next state plus the handshake and multiplier drives; the multiplier sees zeros outside CALC.
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        mul_a        = '0;
        mul_b        = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_grant_onehot;
                if (w_accept) begin
`ifdef MULT_SCHED_ZERO_SKIP_EN
                    w_next_state = w_zero_op ? ST_RESP : ST_CALC;
`else
                    w_next_state = ST_CALC;
`endif
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CALC: begin
                mul_a        = r_op_a;
                mul_b        = r_op_b;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture and round-robin pointer update on each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= ID_W'(NUM_REQ - 1);
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_op_id <= '0;
        end else if (w_accept) begin
            r_ptr   <= w_grant_idx;
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_op_id <= w_grant_idx;
        end
    end

    // Response register; id and product deliberately hold after the response is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef MULT_SCHED_ZERO_SKIP_EN
                    if (w_accept && w_zero_op) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_id      <= w_grant_idx;
                        r_rsp_product <= '0;
                    end else begin
                        r_rsp_valid   <= r_rsp_valid;
                    end
`else
                    r_rsp_valid <= r_rsp_valid;
`endif
                end
                ST_CALC: begin
                    r_rsp_valid   <= 1'b1;
                    r_rsp_id      <= r_op_id;
                    r_rsp_product <= mul_product;
                end
                ST_RESP: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end else begin
                        r_rsp_valid <= r_rsp_valid;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: directed scenarios plus a random
// run against a cycle-level behavioural model of arbitration and latency.
module tb_mult_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [2*WIDTH-1:0]       mul_product;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [2*WIDTH-1:0]       rsp_product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared combinational multiplier.
    assign mul_product = {4'd0, mul_a} * {4'd0, mul_b};

    mult_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid[idx]             = 1'b1;
        req_a[idx*WIDTH +: WIDTH]  = a;
        req_b[idx*WIDTH +: WIDTH]  = b;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        @(posedge clk);
        #3 rst_n  = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (rsp_product !== 8'd0) begin errors++; $display("FAIL reset_rsp_product got %0h exp 0", rsp_product); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if ({mul_a, mul_b} !== 8'd0) begin errors++; $display("FAIL reset_mul got %0h/%0h exp 0/0", mul_a, mul_b); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_prio got %b exp 0001", req_ready); end
        req_valid = 4'b0000;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_withdraw got %b exp 0000", req_ready); end
    endtask

    task automatic test_single();
        set_req(0, 4'd3, 4'd5);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_calc_valid got %b exp 0", rsp_valid); end
        checks++; if (mul_a !== 4'd3 || mul_b !== 4'd5) begin errors++; $display("FAIL single_mul got %0d/%0d exp 3/5", mul_a, mul_b); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 8'd15) begin
            errors++; $display("FAIL single_rsp got v=%b id=%0d p=%0d exp v=1 id=0 p=15", rsp_valid, rsp_id, rsp_product); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_product !== 8'd15) begin
            errors++; $display("FAIL single_after got v=%b p=%0d exp v=0 p=15", rsp_valid, rsp_product); end
    endtask

    task automatic test_max();
        set_req(2, 4'd15, 4'd15);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL max_ready got %b exp 0100", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_product !== 8'hE1) begin
            errors++; $display("FAIL max_rsp got v=%b id=%0d p=%0h exp v=1 id=2 p=e1", rsp_valid, rsp_id, rsp_product); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_p;
        int         e;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, WIDTH'(i + 2), WIDTH'(13 - i));
        for (int g = 0; g < 5; g++) begin
            e     = g % NUM_REQ;
            exp_p = 8'((e + 2) * (13 - e));
            #1;
            checks++; if (req_ready !== (4'b0001 << e)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", g, req_ready, 4'b0001 << e); end
            tick();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_calc_ready%0d got %b exp 0000", g, req_ready); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(e) || rsp_product !== exp_p) begin
                errors++; $display("FAIL rr_rsp%0d got v=%b id=%0d p=%0d exp v=1 id=%0d p=%0d", g, rsp_valid, rsp_id, rsp_product, e, exp_p); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_back_pressure();
        set_req(1, 4'd6, 4'd7);
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready got %b exp 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        set_req(3, 4'd2, 4'd3);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_product !== 8'd42 || req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_hold%0d got v=%b id=%0d p=%0d rdy=%b exp v=1 id=1 p=42 rdy=0000", c, rsp_valid, rsp_id, rsp_product, req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            errors++; $display("FAIL bp_idle got v=%b rdy=%b exp v=0 rdy=1000", rsp_valid, req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_product !== 8'd6) begin
            errors++; $display("FAIL bp_next got v=%b id=%0d p=%0d exp v=1 id=3 p=6", rsp_valid, rsp_id, rsp_product); end
        tick();
    endtask

    task automatic test_reset_in_calc();
        set_req(2, 4'd7, 4'd9);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_ready got %b exp 0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (mul_a !== 4'd7 || mul_b !== 4'd9) begin errors++; $display("FAIL rst_calc_mul got %0d/%0d exp 7/9", mul_a, mul_b); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || mul_a !== 4'd0 || mul_b !== 4'd0) begin
            errors++; $display("FAIL rst_async got v=%b mul=%0d/%0d exp v=0 mul=0/0", rsp_valid, mul_a, mul_b); end
        checks++; if (rsp_id !== 2'd0 || rsp_product !== 8'd0) begin
            errors++; $display("FAIL rst_rsp_clear got id=%0d p=%0d exp 0/0", rsp_id, rsp_product); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++; if (rsp_valid !== 1'b0 || rsp_product !== 8'd0) begin
                errors++; $display("FAIL rst_stale%0d got v=%b p=%0d exp v=0 p=0", c, rsp_valid, rsp_product); end
            tick();
        end
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'd1, 4'd1);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_prio got %b exp 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_zero_operand();
        set_req(1, 4'd0, 4'd12);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_ready got %b exp 0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
`ifdef MULT_SCHED_ZERO_SKIP_EN
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_product !== 8'd0 || mul_a !== 4'd0 || mul_b !== 4'd0) begin
            errors++; $display("FAIL zero_skip got v=%b id=%0d p=%0d mul=%0d/%0d exp v=1 id=1 p=0 mul=0/0", rsp_valid, rsp_id, rsp_product, mul_a, mul_b); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL zero_done got %b exp 0", rsp_valid); end
`else
        checks++; if (rsp_valid !== 1'b0 || mul_a !== 4'd0 || mul_b !== 4'd12) begin
            errors++; $display("FAIL zero_calc got v=%b mul=%0d/%0d exp v=0 mul=0/12", rsp_valid, mul_a, mul_b); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_product !== 8'd0) begin
            errors++; $display("FAIL zero_rsp got v=%b id=%0d p=%0d exp v=1 id=1 p=0", rsp_valid, rsp_id, rsp_product); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL zero_done got %b exp 0", rsp_valid); end
`endif
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pv;
        logic [WIDTH-1:0]   pa [NUM_REQ];
        logic [WIDTH-1:0]   pb [NUM_REQ];
        logic [WIDTH-1:0]   cur_a, cur_b;
        logic [7:0]         cur_p, shown_p;
        logic [NUM_REQ-1:0] rdy_exp;
        logic               rv_exp, calc_exp;
        int                 cur_id, shown_id, last, busy, acc, lat, win;
        apply_reset();
        pv = '0; last = NUM_REQ - 1; busy = 0; acc = 0; lat = 2; win = -1;
        cur_id = 0; shown_id = 0; cur_a = '0; cur_b = '0; cur_p = '0; shown_p = '0;
        for (int i = 0; i < NUM_REQ; i++) begin pa[i] = '0; pb[i] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pa[i] = ($urandom_range(0, 4) == 0) ? 4'd0 : WIDTH'($urandom_range(0, 15));
                    pb[i] = ($urandom_range(0, 4) == 0) ? 4'd0 : WIDTH'($urandom_range(0, 15));
                    set_req(i, pa[i], pb[i]);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            win = -1;
            if (busy == 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (win < 0 && pv[(last + k) % NUM_REQ]) win = (last + k) % NUM_REQ;
                end
            end
            rdy_exp  = (win >= 0) ? (NUM_REQ'(1) << win) : '0;
            calc_exp = (busy != 0) && (lat == 2) && (cyc == acc + 1);
            rv_exp   = (busy != 0) && (cyc >= acc + lat);
            if (rv_exp) begin shown_id = cur_id; shown_p = cur_p; end
            checks++; if (req_ready !== rdy_exp) begin errors++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cyc, req_ready, rdy_exp); end
            checks++; if (rsp_valid !== rv_exp) begin errors++; $display("FAIL rand_valid cyc=%0d got %b exp %b", cyc, rsp_valid, rv_exp); end
            checks++; if (rsp_id !== ID_W'(shown_id)) begin errors++; $display("FAIL rand_id cyc=%0d got %0d exp %0d", cyc, rsp_id, shown_id); end
            checks++; if (rsp_product !== shown_p) begin errors++; $display("FAIL rand_product cyc=%0d got %0d exp %0d", cyc, rsp_product, shown_p); end
            checks++; if (mul_a !== (calc_exp ? cur_a : 4'd0)) begin errors++; $display("FAIL rand_mul_a cyc=%0d got %0d", cyc, mul_a); end
            checks++; if (mul_b !== (calc_exp ? cur_b : 4'd0)) begin errors++; $display("FAIL rand_mul_b cyc=%0d got %0d", cyc, mul_b); end
            if (win >= 0) begin
                busy   = 1; acc = cyc; last = win; cur_id = win;
                cur_a  = pa[win]; cur_b = pb[win];
                cur_p  = 8'(int'(pa[win]) * int'(pb[win]));
                lat    = 2;
`ifdef MULT_SCHED_ZERO_SKIP_EN
                if (pa[win] == 4'd0 || pb[win] == 4'd0) lat = 1;
`endif
                pv[win] = 1'b0;
            end else if (rv_exp && rsp_ready) begin
                busy = 0;
            end
            tick();
            req_valid = pv;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_round_robin();
        test_back_pressure();
        test_reset_in_calc();
        test_zero_operand();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
